// File: rtl/avg_feeder_if.sv
// Host-side port bundle for avg_feeder: upstream sample handshake and result FIFO pop port.
interface avg_feeder_if #(
   parameter int unsigned DW = 16
) ();
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic          res_ack;

   // Feeder side.
   modport slave (
      input  in_valid, in_data, res_ack,
      output in_ready, res_valid, res_data
   );

   // Host / stimulus side.
   modport master (
      output in_valid, in_data, res_ack,
      input  in_ready, res_valid, res_data
   );
endinterface

// File: rtl/avg_feeder.sv
// avg_feeder: buffers one frame, streams it into the sliding-window averager one sample per
// clock, and captures every full-window result into a FIFO for the host.
// Optional protocol check compiled in with `define AVG_FEEDER_CHECK_EN.
module avg_feeder #(
   parameter int unsigned DW    = 16,
   parameter int unsigned WIN   = 12,
   parameter int unsigned FRAME = 24
) (
   input  logic          clk_i,
   input  logic          reset_i,
   avg_feeder_if.slave   host_io,
   output logic          avg_rst_o,
   output logic [DW-1:0] avg_din_o,
   input  logic          avg_ready_i,
   input  logic [DW-1:0] avg_dout_i,
   output logic          busy_o,
   output logic          err_o
);

   localparam int unsigned NRES = FRAME - WIN + 1;
   localparam int unsigned CW   = $clog2(FRAME + 1);
   localparam int unsigned PW   = (NRES > 1) ? $clog2(NRES) : 1;
   localparam int unsigned NW   = $clog2(NRES + 1);

   typedef enum logic [0:0] {StLoad, StStream} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] ld_cnt_q, ld_cnt_d;
   logic [CW-1:0] s_cnt_q, s_cnt_d;
   logic [CW-1:0] s_nxt;
   logic          avg_rst_q, avg_rst_d;
   logic [DW-1:0] avg_din_q, avg_din_d;
   logic [DW-1:0] frame_q [FRAME];

   logic [DW-1:0] res_mem_q [NRES];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [NW-1:0] res_cnt_q, res_cnt_d;

   logic accept, capture, pop, res_valid;

   assign res_valid        = (res_cnt_q != '0);
   assign pop              = res_valid && host_io.res_ack;
   assign host_io.in_ready = (state_q == StLoad) && (ld_cnt_q < CW'(FRAME));
   assign accept           = host_io.in_valid && host_io.in_ready;
   assign s_nxt            = s_cnt_q + CW'(1);

   assign host_io.res_valid = res_valid;
   // Head is forced to zero while empty so the FIFO RAM needs no reset.
   assign host_io.res_data  = res_valid ? res_mem_q[rd_ptr_q] : '0;
   assign avg_rst_o         = avg_rst_q;
   assign avg_din_o         = avg_din_q;
   assign busy_o            = (state_q == StStream);

   // Next-state logic: load until full and FIFO drained, then stream FRAME samples.
   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      s_cnt_d   = s_cnt_q;
      avg_rst_d = avg_rst_q;
      avg_din_d = avg_din_q;
      capture   = 1'b0;
      unique case (state_q)
         StLoad: begin
            if (accept) begin
               ld_cnt_d = ld_cnt_q + CW'(1);
            end else if (ld_cnt_q == CW'(FRAME) && !res_valid) begin
               state_d   = StStream;
               s_cnt_d   = '0;
               avg_rst_d = 1'b0;
               avg_din_d = frame_q[0];
            end
         end
         StStream: begin
            capture = (s_cnt_q >= CW'(WIN - 1));
            if (s_cnt_q == CW'(FRAME - 1)) begin
               state_d   = StLoad;
               ld_cnt_d  = '0;
               avg_rst_d = 1'b1;
            end else begin
               s_cnt_d   = s_nxt;
               avg_din_d = frame_q[s_nxt];
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= StLoad;
         ld_cnt_q  <= '0;
         s_cnt_q   <= '0;
         avg_rst_q <= 1'b1;
         avg_din_q <= '0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         s_cnt_q   <= s_cnt_d;
         avg_rst_q <= avg_rst_d;
         avg_din_q <= avg_din_d;
      end
   end

   // Frame buffer write port; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         frame_q[ld_cnt_q] <= host_io.in_data;
      end
   end

   // Result count: simultaneous push and pop leaves it unchanged.
   always_comb begin
      res_cnt_d = res_cnt_q;
      if (capture && !pop) begin
         res_cnt_d = res_cnt_q + NW'(1);
      end else if (!capture && pop) begin
         res_cnt_d = res_cnt_q - NW'(1);
      end
   end

   // Result FIFO pointers and occupancy.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         res_cnt_q <= '0;
      end else begin
         res_cnt_q <= res_cnt_d;
         if (capture) begin
            wr_ptr_q <= (wr_ptr_q == PW'(NRES - 1)) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PW'(NRES - 1)) ? '0 : rd_ptr_q + PW'(1);
         end
      end
   end

   // Result FIFO storage.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         res_mem_q[wr_ptr_q] <= avg_dout_i;
      end
   end

`ifdef AVG_FEEDER_CHECK_EN
   logic err_q;
   // Sticky error: a result captured while the averager window was not full.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_q <= 1'b0;
      end else if (capture && !avg_ready_i) begin
         err_q <= 1'b1;
      end
   end
   assign err_o = err_q;
`else
   logic unused_avg_ready;
   assign unused_avg_ready = avg_ready_i;
   assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_avg_feeder.sv
module tb_avg_feeder;
   localparam int unsigned DW    = 16;
   localparam int unsigned WIN   = 12;
   localparam int unsigned FRAME = 24;
   localparam int unsigned NRES  = FRAME - WIN + 1;

   typedef logic [DW-1:0] frame_t [FRAME];
   typedef logic [DW-1:0] win_t [WIN];

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          avg_rst;
   logic [DW-1:0] avg_din;
   logic          avg_ready;
   logic [DW-1:0] avg_dout;
   logic          busy;
   logic          err;
   logic          force_nr = 1'b0;

   int checks   = 0;
   int failures = 0;
   int pop_cnt  = 0;
   logic [DW-1:0] exp_q [$];

   avg_feeder_if #(.DW(DW)) host ();

   avg_feeder #(.DW(DW), .WIN(WIN), .FRAME(FRAME)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .host_io     (host),
      .avg_rst_o   (avg_rst),
      .avg_din_o   (avg_din),
      .avg_ready_i (avg_ready),
      .avg_dout_i  (avg_dout),
      .busy_o      (busy),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   // Averager model: nearest window sample to the truncated mean.
   function automatic logic [DW-1:0] nearest(input win_t w);
      int unsigned sum, mean, d, bd;
      logic [DW-1:0] b;
      sum = 0;
      for (int j = 0; j < WIN; j++) sum += 32'(w[j]);
      mean = sum / WIN;
      b  = w[0];
      bd = (32'(w[0]) > mean) ? 32'(w[0]) - mean : mean - 32'(w[0]);
      for (int j = 1; j < WIN; j++) begin
         d = (32'(w[j]) > mean) ? 32'(w[j]) - mean : mean - 32'(w[j]);
         if (d < bd) begin
            bd = d;
            b  = w[j];
         end
      end
      return b;
   endfunction

   win_t win_q;
   int   win_n = 0;

   // Averager shifts on the falling edge; w[0] is the newest sample.
   always @(negedge clk) begin
      if (avg_rst) begin
         win_n <= 0;
      end else begin
         for (int j = WIN - 1; j > 0; j--) win_q[j] <= win_q[j-1];
         win_q[0] <= avg_din;
         win_n    <= (win_n < WIN) ? win_n + 1 : win_n;
      end
   end

   assign avg_dout  = nearest(win_q);
   assign avg_ready = (win_n >= WIN) && !force_nr;

   // Scoreboard consumer: every pop is compared to the oldest expected result.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (!reset && host.res_valid && host.res_ack) begin
            checks++;
            pop_cnt++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result got=%0d required=none", host.res_data);
            end else begin
               e = exp_q.pop_front();
               if (host.res_data !== e) begin
                  failures++;
                  $display("FAIL result got=%0d required=%0d", host.res_data, e);
               end
            end
         end
      end
   end

   task automatic push_model(input frame_t f);
      win_t w;
      for (int s = WIN - 1; s < FRAME; s++) begin
         for (int j = 0; j < WIN; j++) w[j] = f[s-j];
         exp_q.push_back(nearest(w));
      end
   endtask

   task automatic load_frame(input frame_t f);
      int  i = 0;
      int  t = 0;
      bit  rdy;
      while (i < FRAME && t < 2000) begin
         host.in_valid = 1'b1;
         host.in_data  = f[i];
         @(negedge clk);
         rdy = host.in_ready;
         @(posedge clk); #1;
         if (rdy) i++;
         t++;
      end
      host.in_valid = 1'b0;
      checks++;
      if (i != FRAME) begin
         failures++;
         $display("FAIL load_timeout accepted=%0d required=%0d", i, FRAME);
      end
   endtask

   // Waits for a stream, returning its length plus a few snapshots around the first capture.
   task automatic run_stream(output int n, output logic rv11, output logic rv12,
                             output logic er11, output logic er12,
                             output logic [DW-1:0] din0, output logic rst0);
      int t = 0;
      n = 0; rv11 = 1'bx; rv12 = 1'bx; er11 = 1'bx; er12 = 1'bx; din0 = 'x; rst0 = 1'bx;
      while (!busy && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      while (busy && n < 200) begin
         if (n == 0)  begin din0 = avg_din; rst0 = avg_rst; end
         if (n == 11) begin rv11 = host.res_valid; er11 = err; end
         if (n == 12) begin rv12 = host.res_valid; er12 = err; end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks += 8;
      if (avg_rst !== 1'b1)         begin failures++; $display("FAIL rst_avg_rst got=%b required=1", avg_rst); end
      if (host.in_ready !== 1'b1)   begin failures++; $display("FAIL rst_in_ready got=%b required=1", host.in_ready); end
      if (host.res_valid !== 1'b0)  begin failures++; $display("FAIL rst_res_valid got=%b required=0", host.res_valid); end
      if (busy !== 1'b0)            begin failures++; $display("FAIL rst_busy got=%b required=0", busy); end
      if (err !== 1'b0)             begin failures++; $display("FAIL rst_err got=%b required=0", err); end
      if (avg_din !== '0)           begin failures++; $display("FAIL rst_avg_din got=%0d required=0", avg_din); end
      if (host.res_data !== '0)     begin failures++; $display("FAIL rst_res_data got=%0d required=0", host.res_data); end
      if (dut.ld_cnt_q !== '0)      begin failures++; $display("FAIL rst_ld_cnt got=%0d required=0", dut.ld_cnt_q); end
   endtask

   task automatic test_ramp();
      frame_t f;
      int n;
      logic rv11, rv12, er11, er12, rst0;
      logic [DW-1:0] din0;
      for (int i = 0; i < FRAME; i++) f[i] = DW'(i + 1);
      for (int k = 0; k < NRES; k++) exp_q.push_back(DW'(k + 6));
      host.res_ack = 1'b1;
      load_frame(f);
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      checks += 6;
      if (n != FRAME)        begin failures++; $display("FAIL ramp_busy_cycles got=%0d required=%0d", n, FRAME); end
      if (din0 !== DW'(1))   begin failures++; $display("FAIL ramp_first_din got=%0d required=1", din0); end
      if (rst0 !== 1'b0)     begin failures++; $display("FAIL ramp_stream_rst got=%b required=0", rst0); end
      if (rv11 !== 1'b0)     begin failures++; $display("FAIL ramp_res_valid_early got=%b required=0", rv11); end
      if (rv12 !== 1'b1)     begin failures++; $display("FAIL ramp_first_result got=%b required=1", rv12); end
      if (avg_rst !== 1'b1)  begin failures++; $display("FAIL ramp_rst_after got=%b required=1", avg_rst); end
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL ramp_drain left=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_flat();
      frame_t f;
      int n;
      logic rv11, rv12, er11, er12, rst0;
      logic [DW-1:0] din0;
      for (int i = 0; i < FRAME; i++) f[i] = DW'(100);
      for (int k = 0; k < NRES; k++) exp_q.push_back(DW'(100));
      load_frame(f);
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      wait_drain();
      checks += 2;
      if (exp_q.size() != 0) begin failures++; $display("FAIL flat_drain left=%0d required=0", exp_q.size()); end
      if (err !== 1'b0)      begin failures++; $display("FAIL flat_err got=%b required=0", err); end
   endtask

   task automatic test_backpressure();
      frame_t fa, fb;
      int n;
      logic rv11, rv12, er11, er12, rst0;
      logic [DW-1:0] din0;
      for (int i = 0; i < FRAME; i++) begin
         fa[i] = DW'($urandom_range(0, 1000));
         fb[i] = DW'($urandom_range(0, 60000));
      end
      host.res_ack = 1'b0;
      push_model(fa);
      load_frame(fa);
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      push_model(fb);
      load_frame(fb);
      checks++;
      if (host.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b required=0", host.in_ready); end
      repeat (6) @(posedge clk);
      #1;
      checks += 2;
      if (busy !== 1'b0)           begin failures++; $display("FAIL bp_no_stream got=%b required=0", busy); end
      if (host.res_valid !== 1'b1) begin failures++; $display("FAIL bp_res_held got=%b required=1", host.res_valid); end
      host.res_ack = 1'b1;
      repeat (NRES) @(posedge clk);
      #1;
      checks += 2;
      if (host.res_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b required=0", host.res_valid); end
      if (busy !== 1'b0)           begin failures++; $display("FAIL bp_busy_before got=%b required=0", busy); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b1)           begin failures++; $display("FAIL bp_stream_start got=%b required=1", busy); end
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      wait_drain();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain left=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      frame_t f;
      int n = 0;
      int t = 0;
      int p0;
      logic rv11, rv12, er11, er12, rst0;
      logic [DW-1:0] din0;
      for (int i = 0; i < FRAME; i++) f[i] = DW'(i + 1);
      for (int k = 0; k < NRES; k++) exp_q.push_back(DW'(k + 6));
      load_frame(f);
      while (!busy && t < 100) begin @(posedge clk); #1; t++; end
      while (n < 15) begin @(posedge clk); #1; n++; end
      reset = 1'b1;
      #1;
      checks += 5;
      if (avg_rst !== 1'b1)        begin failures++; $display("FAIL mid_avg_rst got=%b required=1", avg_rst); end
      if (host.res_valid !== 1'b0) begin failures++; $display("FAIL mid_res_valid got=%b required=0", host.res_valid); end
      if (host.in_ready !== 1'b1)  begin failures++; $display("FAIL mid_in_ready got=%b required=1", host.in_ready); end
      if (busy !== 1'b0)           begin failures++; $display("FAIL mid_busy got=%b required=0", busy); end
      if (dut.ld_cnt_q !== '0)     begin failures++; $display("FAIL mid_ld_cnt got=%0d required=0", dut.ld_cnt_q); end
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      p0 = pop_cnt;
      for (int i = 0; i < FRAME; i++) f[i] = DW'($urandom_range(0, 5000));
      push_model(f);
      load_frame(f);
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      wait_drain();
      checks++;
      if (pop_cnt - p0 != NRES) begin failures++; $display("FAIL mid_result_count got=%0d required=%0d", pop_cnt - p0, NRES); end
   endtask

   task automatic test_ivalid_stream();
      frame_t f;
      int t = 0;
      int n = 0;
      int bad = 0;
      for (int i = 0; i < FRAME; i++) f[i] = DW'($urandom_range(0, 3000));
      push_model(f);
      load_frame(f);
      while (!busy && t < 100) begin @(posedge clk); #1; t++; end
      while (busy && n < 100) begin
         host.in_valid = n[0];
         host.in_data  = DW'($urandom);
         if (host.in_ready !== 1'b0) bad++;
         @(posedge clk); #1;
         n++;
      end
      host.in_valid = 1'b0;
      checks += 3;
      if (n != FRAME)          begin failures++; $display("FAIL iv_stream_len got=%0d required=%0d", n, FRAME); end
      if (bad != 0)            begin failures++; $display("FAIL iv_in_ready_cycles got=%0d required=0", bad); end
      if (dut.ld_cnt_q !== '0) begin failures++; $display("FAIL iv_ld_cnt got=%0d required=0", dut.ld_cnt_q); end
      wait_drain();
      checks++;
      if (exp_q.size() != 0)   begin failures++; $display("FAIL iv_drain left=%0d required=0", exp_q.size()); end
   endtask

   task automatic test_err();
      frame_t f;
      int n;
      logic rv11, rv12, er11, er12, rst0;
      logic [DW-1:0] din0;
      for (int i = 0; i < FRAME; i++) f[i] = DW'(i + 1);
      for (int k = 0; k < NRES; k++) exp_q.push_back(DW'(k + 6));
      force_nr = 1'b1;
      load_frame(f);
      run_stream(n, rv11, rv12, er11, er12, din0, rst0);
      wait_drain();
`ifdef AVG_FEEDER_CHECK_EN
      checks += 3;
      if (er11 !== 1'b0) begin failures++; $display("FAIL err_early got=%b required=0", er11); end
      if (er12 !== 1'b1) begin failures++; $display("FAIL err_first_capture got=%b required=1", er12); end
      if (err !== 1'b1)  begin failures++; $display("FAIL err_sticky got=%b required=1", err); end
      force_nr = 1'b0;
      do_reset();
      checks++;
      if (err !== 1'b0)  begin failures++; $display("FAIL err_cleared got=%b required=0", err); end
`else
      checks += 2;
      if (er12 !== 1'b0) begin failures++; $display("FAIL err_tied_stream got=%b required=0", er12); end
      if (err !== 1'b0)  begin failures++; $display("FAIL err_tied got=%b required=0", err); end
      force_nr = 1'b0;
`endif
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL err_drain left=%0d required=0", exp_q.size()); end
   endtask

   initial begin
      host.in_valid = 1'b0;
      host.in_data  = '0;
      host.res_ack  = 1'b1;
      test_reset();
      test_ramp();
      test_flat();
      test_backpressure();
      test_reset_mid();
      test_ivalid_stream();
      test_err();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
